serial_cmd_responder: RTL and testbench
=======================================

SERIAL_CMD_RESPONDER -- requirements
Module: serial_cmd_responder

Interface
REQ-001 Parameter NUM_CH, default 3: number of selectable data channels, range 1..16.
REQ-002 Parameter DATA_W, default 16: bits per channel, range 1..64; NBYTES = ceil(DATA_W/8).
REQ-003 Parameter CMD_BASE, default 8'd120 ('x'): command byte for channel 0; channel k is selected by CMD_BASE+k.
REQ-004 CLK_50  in  1  system clock; all logic is on the rising edge.
REQ-005 iRSTN  in  1  asynchronous active-low reset.
REQ-006 rx_data  in  8  byte from the UART receiver; valid when rx_ready is high.
REQ-007 rx_ready  in  1  one-cycle pulse, one per received byte.
REQ-008 ch_data  in  NUM_CH*DATA_W  packed channel words; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-009 tx_data  out  8  byte to the UART transmitter.
REQ-010 tx_start  out  1  one-cycle request to transmit tx_data.
REQ-011 tx_busy  in  1  transmitter busy; rises no later than 2 cycles after tx_start.
REQ-012 sel_ch  out  max(1,clog2(NUM_CH))  index of the last valid command's channel.
REQ-013 busy  out  1  high from command acceptance until the last byte completes.
REQ-014 cmd_err  out  1  one-cycle pulse on an invalid command byte received while idle.
REQ-015 overrun  out  1  one-cycle pulse on any rx_ready while busy is high.

Function
REQ-016 FSM states: IDLE, LOAD, START, WAIT_HI, WAIT_LO; the FSM is fully synchronous to CLK_50.
REQ-017 IDLE: on rx_ready with CMD_BASE <= rx_data < CMD_BASE+NUM_CH, the block updates sel_ch, sets busy, and goes to LOAD on the next cycle.
REQ-018 IDLE: on rx_ready with any other rx_data, the block pulses cmd_err, stays in IDLE, and leaves sel_ch unchanged.
REQ-019 LOAD: the block snapshots the selected ch_data word, zero-extended to NBYTES*8 bits, into a shift register; it clears the byte counter; it goes to START.
REQ-020 START: the block waits while tx_busy=1; when tx_busy=0, it drives the low byte of the shift register onto tx_data, pulses tx_start for exactly one cycle, and goes to WAIT_HI.
REQ-021 WAIT_HI: the block waits for tx_busy=1, then goes to WAIT_LO; if tx_busy is not seen within 4 cycles, it goes to WAIT_LO anyway.
REQ-022 WAIT_LO: on tx_busy=0, the block shifts the register right by 8, increments the counter, and goes to START if bytes remain, otherwise to IDLE with busy cleared.
REQ-023 Byte order is least significant byte first; exactly NBYTES bytes are sent, plus the checksum byte when enabled (REQ-030).
REQ-024 tx_data holds its value from the tx_start cycle until the next tx_start.
REQ-025 While busy, rx_ready is not decoded as a command: it pulses overrun, and the FSM, sel_ch and the shift register are unaffected.
REQ-026 Changes on ch_data after LOAD have no effect on the bytes sent.
REQ-027 The minimum gap from the end of a transfer (busy low) to acceptance of the next command is one cycle.

Reset
REQ-028 With iRSTN low, the FSM is in IDLE and all outputs are 0: tx_data=8'h00, tx_start=0, sel_ch=0, busy=0, cmd_err=0, overrun=0; the shift register and counter are cleared.
REQ-029 Reset asserted mid-transfer aborts the transfer immediately, with no further tx_start; after release the block accepts a new command.

Configuration
REQ-030 Macro SERIAL_CMD_CHECKSUM_EN defined: after the data bytes, the block sends one extra byte equal to the XOR of all data bytes, using the same START/WAIT handshake.
REQ-031 Macro SERIAL_CMD_CHECKSUM_EN undefined: the block sends only the NBYTES data bytes and contains no checksum logic.

Verification
REQ-032 Defaults, ch_data[31:16]=16'hA5C3, rx 8'h79 -> sel_ch=1, tx bytes C3 then A5, busy low after the second tx_busy fall; with CHECKSUM_EN a third byte 66.
REQ-033 rx 8'h41 while idle -> one cmd_err pulse, no tx_start, sel_ch unchanged.
REQ-034 rx 8'h7A, then rx 8'h78 during the first byte -> one overrun pulse, only channel 2's bytes sent, sel_ch=2.
REQ-035 ch_data changed to 16'hFFFF one cycle after LOAD -> the originally sampled bytes are sent.
REQ-036 DATA_W=12, NUM_CH=4, ch3=12'hABC, rx 8'h7B -> tx BC then 0A.
REQ-037 iRSTN pulsed low after the first tx_start of a 2-byte transfer -> no second tx_start, all outputs 0; a subsequent rx 8'h78 is serviced normally.

Source files
------------

// File: rtl/serial_cmd_responder.sv
// ---------------------------------------------------------------------------
// serial_cmd_responder
//
// Decodes single-byte commands from a UART receiver. Command CMD_BASE+k
// selects channel k. The selected channel word is snapshotted and sent to a
// UART transmitter least-significant byte first, one byte per
// tx_start/tx_busy handshake.
//
// Optional feature macro: SERIAL_CMD_CHECKSUM_EN
//   When defined, one extra byte is appended to each response. It is the XOR
//   of all data bytes and uses the same handshake as the data bytes.
//
// Parameters
//   NUM_CH    number of selectable channels (1..16)
//   DATA_W    bits per channel word (1..64)
//   CMD_BASE  command byte that selects channel 0
//
// Ports
//   CLK_50    system clock; all logic is on the rising edge
//   iRSTN     asynchronous active-low reset
//   rx_data   received byte; valid while rx_ready is high
//   rx_ready  one-cycle strobe, one per received byte
//   ch_data   packed channel words; channel k is [k*DATA_W +: DATA_W]
//   tx_data   byte to transmit; held until the next tx_start
//   tx_start  one-cycle transmit request
//   tx_busy   transmitter busy
//   sel_ch    channel index of the last valid command
//   busy      high from command acceptance until the last byte completes
//   cmd_err   one-cycle pulse for an invalid command received while idle
//   overrun   one-cycle pulse for any received byte while busy
// ---------------------------------------------------------------------------
module serial_cmd_responder #(
    parameter int          NUM_CH   = 3,
    parameter int          DATA_W   = 16,
    parameter logic [7:0]  CMD_BASE = 8'd120,
    localparam int         SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     CLK_50,
    input  logic                     iRSTN,
    input  logic [7:0]               rx_data,
    input  logic                     rx_ready,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    input  logic                     tx_busy,
    output logic [SEL_W-1:0]         sel_ch,
    output logic                     busy,
    output logic                     cmd_err,
    output logic                     overrun
);

    localparam int NBYTES = (DATA_W + 7) / 8;
    localparam int SH_W   = NBYTES * 8;
`ifdef SERIAL_CMD_CHECKSUM_EN
    localparam int TOTAL  = NBYTES + 1;
`else
    localparam int TOTAL  = NBYTES;
`endif
    localparam int CNT_W  = 4;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_ch_q, sel_ch_d;
    logic               busy_q, busy_d;
    logic               cmd_err_q, cmd_err_d;
    logic               overrun_q, overrun_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;
    logic [SH_W-1:0]    shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         wait_q, wait_d;
`ifdef SERIAL_CMD_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    // Command decode in 9 bits so CMD_BASE+NUM_CH can never wrap past 255.
    logic [8:0]         cmd_off;
    logic               cmd_hit;
    logic [SEL_W-1:0]   cmd_idx;

    assign cmd_off = {1'b0, rx_data} - {1'b0, CMD_BASE};
    assign cmd_hit = (rx_data >= CMD_BASE) && (cmd_off < 9'(NUM_CH));
    assign cmd_idx = cmd_off[SEL_W-1:0];

    // Channel mux with constant part-selects; only indices below NUM_CH
    // can ever be stored in sel_ch_q.
    logic [DATA_W-1:0]  ch_word;

    always_comb begin
        ch_word = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel_ch_q == SEL_W'(k)) begin
                ch_word = ch_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        // NOTE: every signal gets a default before the case statement, so no
        // path leaves one unassigned and no latch can be inferred.
        state_d    = state_q;
        sel_ch_d   = sel_ch_q;
        busy_d     = busy_q;
        cmd_err_d  = 1'b0;
        overrun_d  = rx_ready && busy_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        wait_d     = wait_q;
`ifdef SERIAL_CMD_CHECKSUM_EN
        csum_d     = csum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (rx_ready) begin
                    if (cmd_hit) begin
                        sel_ch_d = cmd_idx;
                        busy_d   = 1'b1;
                        state_d  = S_LOAD;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end

            S_LOAD: begin
                // Snapshot here; later ch_data changes cannot affect the reply.
                shreg_d = SH_W'(ch_word);
                cnt_d   = '0;
`ifdef SERIAL_CMD_CHECKSUM_EN
                csum_d  = '0;
`endif
                state_d = S_START;
            end

            S_START: begin
                if (!tx_busy) begin
                    tx_data_d  = shreg_q[7:0];
                    tx_start_d = 1'b1;
                    wait_d     = '0;
                    state_d    = S_WAIT_HI;
`ifdef SERIAL_CMD_CHECKSUM_EN
                    if (cnt_q < CNT_W'(NBYTES)) begin
                        csum_d = csum_q ^ shreg_q[7:0];
                    end
`endif
                end
            end

            S_WAIT_HI: begin
                // Give up after four cycles so a transmitter that never
                // asserts busy cannot stall the block.
                if (tx_busy || (wait_q == 2'd3)) begin
                    state_d = S_WAIT_LO;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end

            S_WAIT_LO: begin
                if (!tx_busy) begin
                    shreg_d = shreg_q >> 8;
                    cnt_d   = cnt_q + CNT_W'(1);
`ifdef SERIAL_CMD_CHECKSUM_EN
                    // After the last data byte, the checksum becomes the
                    // next byte to send.
                    if (cnt_q == CNT_W'(NBYTES - 1)) begin
                        shreg_d[7:0] = csum_q;
                    end
`endif
                    if (cnt_q == LAST_IDX) begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_START;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK_50 or negedge iRSTN) begin
        if (!iRSTN) begin
            state_q    <= S_IDLE;
            sel_ch_q   <= '0;
            busy_q     <= 1'b0;
            cmd_err_q  <= 1'b0;
            overrun_q  <= 1'b0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            // NOTE: the shift register is a datapath register, but it is
            // reset anyway so an aborted transfer leaves no stale data behind.
            shreg_q    <= '0;
            cnt_q      <= '0;
            wait_q     <= '0;
`ifdef SERIAL_CMD_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments only, so every register samples
            // the pre-edge values computed by the combinational block.
            state_q    <= state_d;
            sel_ch_q   <= sel_ch_d;
            busy_q     <= busy_d;
            cmd_err_q  <= cmd_err_d;
            overrun_q  <= overrun_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            shreg_q    <= shreg_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
`ifdef SERIAL_CMD_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign sel_ch   = sel_ch_q;
    assign busy     = busy_q;
    assign cmd_err  = cmd_err_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_serial_cmd_responder.sv
// ---------------------------------------------------------------------------
// tb_serial_cmd_responder
//
// Directed bench for serial_cmd_responder. It uses two instances:
//   dut  - default parameters, with a transmitter model that raises busy
//   dut2 - DATA_W=12, NUM_CH=4, with tx_busy held low so WAIT_HI times out
//
// All outputs are sampled on the falling clock edge. Inputs are driven
// there as well.
// ---------------------------------------------------------------------------
module tb_serial_cmd_responder;

`ifdef SERIAL_CMD_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        CLK_50 = 1'b0;
    logic        iRSTN  = 1'b0;

    // dut (defaults)
    logic [7:0]  rx_data  = 8'h00;
    logic        rx_ready = 1'b0;
    logic [47:0] ch_data;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy  = 1'b0;
    logic [1:0]  sel_ch;
    logic        busy, cmd_err, overrun;

    // dut2 (DATA_W=12, NUM_CH=4)
    logic [7:0]  rx_data2  = 8'h00;
    logic        rx_ready2 = 1'b0;
    logic [47:0] ch_data2;
    logic [7:0]  tx_data2;
    logic        tx_start2;
    logic        tx_busy2  = 1'b0;
    logic [1:0]  sel_ch2;
    logic        busy2, cmd_err2, overrun2;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q1[$];
    logic [7:0] q2[$];
    int err1 = 0, ovr1 = 0, err2 = 0;

    serial_cmd_responder dut (
        .CLK_50(CLK_50), .iRSTN(iRSTN),
        .rx_data(rx_data), .rx_ready(rx_ready), .ch_data(ch_data),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .sel_ch(sel_ch), .busy(busy), .cmd_err(cmd_err), .overrun(overrun)
    );

    serial_cmd_responder #(.NUM_CH(4), .DATA_W(12)) dut2 (
        .CLK_50(CLK_50), .iRSTN(iRSTN),
        .rx_data(rx_data2), .rx_ready(rx_ready2), .ch_data(ch_data2),
        .tx_data(tx_data2), .tx_start(tx_start2), .tx_busy(tx_busy2),
        .sel_ch(sel_ch2), .busy(busy2), .cmd_err(cmd_err2), .overrun(overrun2)
    );

    initial forever #10 CLK_50 = ~CLK_50;

    // Event monitors: capture transmitted bytes and count pulses.
    initial forever begin
        @(negedge CLK_50);
        if (tx_start)  q1.push_back(tx_data);
        if (cmd_err)   err1++;
        if (overrun)   ovr1++;
        if (tx_start2) q2.push_back(tx_data2);
        if (cmd_err2)  err2++;
    end

    // Transmitter model for dut: busy high one cycle after tx_start, for 5 cycles.
    initial forever begin
        @(negedge CLK_50);
        if (tx_start) begin
            tx_busy = 1'b1;
            repeat (5) @(negedge CLK_50);
            tx_busy = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_seq(input string tag, input logic [7:0] got[$], input int n,
                             input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] exp [3];
        exp[0] = b0; exp[1] = b1; exp[2] = b2;
        check({tag, " byte count"}, 64'(got.size()), 64'(n));
        for (int i = 0; i < n && i < got.size(); i++)
            check($sformatf("%s byte%0d", tag, i), 64'(got[i]), 64'(exp[i]));
    endtask

    task automatic send1(input logic [7:0] b);
        @(negedge CLK_50);
        rx_data = b; rx_ready = 1'b1;
        @(negedge CLK_50);
        rx_ready = 1'b0;
    endtask

    task automatic send2(input logic [7:0] b);
        @(negedge CLK_50);
        rx_data2 = b; rx_ready2 = 1'b1;
        @(negedge CLK_50);
        rx_ready2 = 1'b0;
    endtask

    task automatic wait_idle1(input string tag);
        int n = 0;
        while (busy && n < 500) begin @(negedge CLK_50); n++; end
        check({tag, " idle timeout"}, 64'(n >= 500), 64'(0));
        repeat (2) @(negedge CLK_50);
    endtask

    task automatic wait_idle2(input string tag);
        int n = 0;
        while (busy2 && n < 500) begin @(negedge CLK_50); n++; end
        check({tag, " idle timeout"}, 64'(n >= 500), 64'(0));
        repeat (2) @(negedge CLK_50);
    endtask

    task automatic wait_tx1(input string tag, input int k);
        int n = 0;
        while (q1.size() < k && n < 200) begin @(negedge CLK_50); n++; end
        check({tag, " tx_start timeout"}, 64'(n >= 200), 64'(0));
    endtask

    initial begin
        ch_data  = {16'hBEEF, 16'hA5C3, 16'h1234};
        ch_data2 = {12'hABC, 12'h333, 12'h222, 12'h111};

        // Reset state
        repeat (3) @(negedge CLK_50);
        check("rst tx_data",  64'(tx_data),  0);
        check("rst tx_start", 64'(tx_start), 0);
        check("rst sel_ch",   64'(sel_ch),   0);
        check("rst busy",     64'(busy),     0);
        check("rst cmd_err",  64'(cmd_err),  0);
        check("rst overrun",  64'(overrun),  0);
        check("rst busy2",    64'(busy2),    0);
        iRSTN = 1'b1;
        repeat (2) @(negedge CLK_50);

        // Channel 1 = A5C3: send C3 then A5, with checksum 66 when enabled
        q1.delete();
        send1(8'h79);
        check("A busy after accept", 64'(busy), 1);
        check("A sel_ch", 64'(sel_ch), 1);
        wait_idle1("A");
        check_seq("A", q1, 2 + CS, 8'hC3, 8'hA5, 8'h66);
        check("A tx_busy low at end", 64'(tx_busy), 0);

        // Invalid commands: 41, 77 (just below base), 7B (just above the top)
        q1.delete(); err1 = 0;
        send1(8'h41);
        repeat (2) @(negedge CLK_50);
        check("B cmd_err count 41", 64'(err1), 1);
        send1(8'h77);
        send1(8'h7B);
        repeat (20) @(negedge CLK_50);
        check("B cmd_err count all", 64'(err1), 3);
        check("B no tx_start", 64'(q1.size()), 0);
        check("B sel_ch kept", 64'(sel_ch), 1);
        check("B busy", 64'(busy), 0);

        // Overrun: 7A, then 78 during the first byte
        q1.delete(); err1 = 0; ovr1 = 0;
        send1(8'h7A);
        wait_tx1("C", 1);
        send1(8'h78);
        wait_idle1("C");
        check("C overrun count", 64'(ovr1), 1);
        check("C cmd_err count", 64'(err1), 0);
        check("C sel_ch", 64'(sel_ch), 2);
        check_seq("C", q1, 2 + CS, 8'hEF, 8'hBE, 8'h51);

        // ch_data changes one cycle after LOAD: original 1234 bytes are sent
        q1.delete();
        send1(8'h78);
        @(negedge CLK_50);
        ch_data[15:0] = 16'hFFFF;
        wait_idle1("D");
        check("D sel_ch", 64'(sel_ch), 0);
        check_seq("D", q1, 2 + CS, 8'h34, 8'h12, 8'h26);

        // Reset after the first tx_start aborts the transfer
        q1.delete();
        send1(8'h79);
        wait_tx1("E", 1);
        @(negedge CLK_50);
        iRSTN = 1'b0;
        #1;
        check("E rst tx_data",  64'(tx_data),  0);
        check("E rst tx_start", 64'(tx_start), 0);
        check("E rst sel_ch",   64'(sel_ch),   0);
        check("E rst busy",     64'(busy),     0);
        check("E rst cmd_err",  64'(cmd_err),  0);
        check("E rst overrun",  64'(overrun),  0);
        repeat (2) @(negedge CLK_50);
        iRSTN = 1'b1;
        repeat (30) @(negedge CLK_50);
        check("E no second tx_start", 64'(q1.size()), 1);
        q1.delete();
        send1(8'h78);
        wait_idle1("E2");
        check("E2 sel_ch", 64'(sel_ch), 0);
        check_seq("E2", q1, 2 + CS, 8'hFF, 8'hFF, 8'h00);

        // dut2: 12-bit channel 3 = ABC, sent with WAIT_HI timeouts
        q2.delete(); err2 = 0;
        send2(8'h7B);
        wait_idle2("F");
        check("F sel_ch", 64'(sel_ch2), 3);
        check_seq("F", q2, 2 + CS, 8'hBC, 8'h0A, 8'hB6);
        send2(8'h7C);
        repeat (2) @(negedge CLK_50);
        check("F cmd_err 7C", 64'(err2), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
